// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: two master request/response channels, the RAM data port and debug taps.
// m1_lock exists only when ARB_LOCK_EN is defined.
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [3:0]        m0_be;
    logic [31:0]       m0_addr;
    logic [DWIDTH-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DWIDTH-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [3:0]        m1_be;
    logic [31:0]       m1_addr;
    logic [DWIDTH-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DWIDTH-1:0] m1_rdata;
`ifdef ARB_LOCK_EN
    logic              m1_lock;
`endif

    logic              mem_wen;
    logic [3:0]        mem_wbe;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_d;
    logic [DWIDTH-1:0] mem_q;

    // Arbiter state taps: aging counter and lock register.
    logic [7:0]        dbg_wait_cnt;
    logic              dbg_lock;

    // Handshake: a request is accepted in the cycle where req and gnt are both high;
    // read data returns with rvalid exactly one cycle after an accepted read.
    modport slave (
        input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
`ifdef ARB_LOCK_EN
        input  m1_lock,
`endif
        output mem_wen, mem_wbe, mem_addr, mem_d,
        input  mem_q,
        output dbg_wait_cnt, dbg_lock
    );

    modport master (
        output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
`ifdef ARB_LOCK_EN
        output m1_lock,
`endif
        input  mem_wen, mem_wbe, mem_addr, mem_d,
        output mem_q,
        input  dbg_wait_cnt, dbg_lock
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the RAM data port: m0 (CPU) has fixed priority, m1 (loader) is aged so it cannot starve.
// Optional macro ARB_LOCK_EN adds m1_lock for atomic loader bursts.
module mem_port_arbiter #(
    parameter int AWIDTH   = 12,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 8
) (
    input logic clk,
    input logic n_rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0]        wait_cnt;
    logic              force1;
    logic              lock_q;
    logic              m0_gnt;
    logic              m1_gnt;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;
    logic [DWIDTH-1:0] m0_rdata_q;
    logic [DWIDTH-1:0] m1_rdata_q;

    assign force1 = (wait_cnt == MAX_W);

`ifdef ARB_LOCK_EN
    // Lock is taken by a granted m1 access with m1_lock high and released by the
    // first cycle that drops either m1_lock or m1_req.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lock_q <= 1'b0;
        end else if (lock_q) begin
            if (!bus.m1_lock || !bus.m1_req) lock_q <= 1'b0;
        end else if (m1_gnt && bus.m1_lock) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign lock_q = 1'b0;
`endif

    assign m0_gnt = bus.m0_req & ~force1 & ~lock_q;
    assign m1_gnt = bus.m1_req & (~bus.m0_req | force1 | lock_q);

    // A forced grant clears the counter, so m0 wins the next contended cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= 8'd0;
        end else if (lock_q) begin
            wait_cnt <= 8'd0;
        end else if (bus.m1_req && !m1_gnt) begin
            if (wait_cnt != MAX_W) wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    always_comb begin
        bus.mem_wen  = 1'b0;
        bus.mem_wbe  = 4'b0000;
        bus.mem_addr = '0;
        bus.mem_d    = '0;
        if (m0_gnt) begin
            bus.mem_wen  = bus.m0_we;
            bus.mem_wbe  = bus.m0_be;
            bus.mem_addr = bus.m0_addr[AWIDTH+1:2];
            bus.mem_d    = bus.m0_wdata;
        end else if (m1_gnt) begin
            bus.mem_wen  = bus.m1_we;
            bus.mem_wbe  = bus.m1_be;
            bus.mem_addr = bus.m1_addr[AWIDTH+1:2];
            bus.mem_d    = bus.m1_wdata;
        end
    end

    // Read response: mem_q is sampled at the grant edge; rdata holds until the next read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= m0_gnt & ~bus.m0_we;
            m1_rvalid_q <= m1_gnt & ~bus.m1_we;
            if (m0_gnt && !bus.m0_we) m0_rdata_q <= bus.mem_q;
            if (m1_gnt && !bus.m1_we) m1_rdata_q <= bus.mem_q;
        end
    end

    assign bus.m0_gnt       = m0_gnt;
    assign bus.m1_gnt       = m1_gnt;
    assign bus.m0_rvalid    = m0_rvalid_q;
    assign bus.m1_rvalid    = m1_rvalid_q;
    assign bus.m0_rdata     = m0_rdata_q;
    assign bus.m1_rdata     = m1_rdata_q;
    assign bus.dbg_wait_cnt = wait_cnt;
    assign bus.dbg_lock     = lock_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: driver pushes per-cycle port expectations and read data,
// a negedge monitor pops and compares them against a behavioural RAM.
module tb_mem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 1 + 1 + 1 + 4 + AW + DW;

    logic clk;
    logic n_rst;

    mem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    logic [CW-1:0] cyc_q[$];
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic lock_val = 1'b0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // RAM model: asynchronous read, byte-enabled write on the rising edge.
    assign bus.mem_q = ram[bus.mem_addr];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        for (int i = 0; i < 4; i++) ram[i] = 32'hC0DE_0000 + DW'(i);
        ram[4] = 32'hDEAD_BEEF;
        ram[8] = 32'hAAAA_AAAA;
        forever begin
            @(posedge clk);
            if (bus.mem_wen)
                for (int k = 0; k < 4; k++)
                    if (bus.mem_wbe[k]) ram[bus.mem_addr][8*k +: 8] = bus.mem_d[8*k +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(
        input logic        r0, input logic w0, input logic [3:0] b0, input logic [31:0] a0, input logic [DW-1:0] d0,
        input logic        r1, input logic w1, input logic [3:0] b1, input logic [31:0] a1, input logic [DW-1:0] d1,
        input logic        g0, input logic g1, input logic wen, input logic [3:0] wbe,
        input logic [AW-1:0] maddr, input logic [DW-1:0] md);
        @(posedge clk);
        #1;
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_be = b0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_be = b1; bus.m1_addr = a1; bus.m1_wdata = d1;
`ifdef ARB_LOCK_EN
        bus.m1_lock = lock_val;
`endif
        cyc_q.push_back({g0, g1, wen, wbe, maddr, md});
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 32'h0, '0, 0, 0, 4'h0, 32'h0, '0, 0, 0, 0, 4'h0, '0, '0);
    endtask

    task automatic zero_inputs();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_be = '0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_be = '0; bus.m1_addr = '0; bus.m1_wdata = '0;
`ifdef ARB_LOCK_EN
        bus.m1_lock = 1'b0;
`endif
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (n_rst) begin
            if (cyc_q.size() > 0)
                check("port_cycle", 64'({bus.m0_gnt, bus.m1_gnt, bus.mem_wen, bus.mem_wbe, bus.mem_addr, bus.mem_d}),
                      64'(cyc_q.pop_front()));
            if (bus.m0_rvalid) begin
                if (exp0_q.size() == 0) check("m0_rvalid_unexpected", 64'(1), 64'(0));
                else check("m0_rdata", 64'(bus.m0_rdata), 64'(exp0_q.pop_front()));
            end
            if (bus.m1_rvalid) begin
                if (exp1_q.size() == 0) check("m1_rvalid_unexpected", 64'(1), 64'(0));
                else check("m1_rdata", 64'(bus.m1_rdata), 64'(exp1_q.pop_front()));
            end
        end
    end

    initial begin
        zero_inputs();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m0_rvalid", 64'(bus.m0_rvalid), 64'(0));
        check("reset_m1_rvalid", 64'(bus.m1_rvalid), 64'(0));
        check("reset_wait_cnt", 64'(bus.dbg_wait_cnt), 64'(0));
        check("reset_m0_rdata", 64'(bus.m0_rdata), 64'(0));
        n_rst = 1'b1;

        // m0 read of word 4
        drive(1, 0, 4'h0, 32'h0000_0010, '0, 0, 0, 4'h0, 32'h0, '0, 1, 0, 0, 4'h0, 12'd4, '0);
        exp0_q.push_back(32'hDEAD_BEEF);
        // m1 partial write to word 8, then read it back, then alias read by m0
        drive(0, 0, 4'h0, 32'h0, '0, 1, 1, 4'b0011, 32'h0000_0020, 32'h1234_5678,
              0, 1, 1, 4'b0011, 12'd8, 32'h1234_5678);
        drive(0, 0, 4'h0, 32'h0, '0, 1, 0, 4'h0, 32'h0000_0020, '0, 0, 1, 0, 4'h0, 12'd8, '0);
        exp1_q.push_back(32'hAAAA_5678);
        drive(1, 0, 4'h0, 32'hFFFF_4020, '0, 0, 0, 4'h0, 32'h0, '0, 1, 0, 0, 4'h0, 12'd8, '0);
        exp0_q.push_back(32'hAAAA_5678);
        // m0 upper-half write then read of word 12
        drive(1, 1, 4'b1100, 32'h0000_0030, 32'hCAFE_F00D, 0, 0, 4'h0, 32'h0, '0,
              1, 0, 1, 4'b1100, 12'd12, 32'hCAFE_F00D);
        drive(1, 0, 4'h0, 32'h0000_0030, '0, 0, 0, 4'h0, 32'h0, '0, 1, 0, 0, 4'h0, 12'd12, '0);
        exp0_q.push_back(32'hCAFE_0000);
        // m1 back-to-back reads of words 0..3
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 4'h0, 32'h0, '0, 1, 0, 4'h0, 32'(i * 4), '0, 0, 1, 0, 4'h0, AW'(i), '0);
            exp1_q.push_back(32'hC0DE_0000 + DW'(i));
        end
        idle();

        // Continuous contention: m1 forced through once every 9 cycles
        for (int i = 0; i < 20; i++) begin
            if ((i % 9) == 8) begin
                drive(1, 0, 4'h0, 32'h0000_0010, '0, 1, 0, 4'h0, 32'h0000_0004, '0, 0, 1, 0, 4'h0, 12'd1, '0);
                exp1_q.push_back(32'hC0DE_0001);
            end else begin
                drive(1, 0, 4'h0, 32'h0000_0010, '0, 1, 0, 4'h0, 32'h0000_0004, '0, 1, 0, 0, 4'h0, 12'd4, '0);
                exp0_q.push_back(32'hDEAD_BEEF);
            end
        end
        idle();

        // Reset during an m0 read grant with a response in flight and wait_cnt nonzero
        drive(1, 0, 4'h0, 32'h0000_0010, '0, 1, 0, 4'h0, 32'h0000_0004, '0, 1, 0, 0, 4'h0, 12'd4, '0);
        exp0_q.push_back(32'hDEAD_BEEF);
        drive(1, 0, 4'h0, 32'h0000_0010, '0, 1, 0, 4'h0, 32'h0000_0004, '0, 1, 0, 0, 4'h0, 12'd4, '0);
        @(negedge clk);
        #1;
        check("pre_reset_wait_cnt", 64'(bus.dbg_wait_cnt), 64'(1));
        check("pre_reset_m0_rvalid", 64'(bus.m0_rvalid), 64'(1));
        n_rst = 1'b0;
        #1;
        check("midreset_m0_rvalid", 64'(bus.m0_rvalid), 64'(0));
        check("midreset_wait_cnt", 64'(bus.dbg_wait_cnt), 64'(0));
        check("midreset_m0_rdata", 64'(bus.m0_rdata), 64'(0));
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive(1, 0, 4'h0, 32'h0000_0010, '0, 0, 0, 4'h0, 32'h0, '0, 1, 0, 0, 4'h0, 12'd4, '0);
        exp0_q.push_back(32'hDEAD_BEEF);
        idle();

`ifdef ARB_LOCK_EN
        // Locked m1 burst holds off m0 until the cycle after m1_lock drops
        lock_val = 1'b1;
        drive(0, 0, 4'h0, 32'h0, '0, 1, 1, 4'hF, 32'h0000_0100, 32'h1111_1111,
              0, 1, 1, 4'hF, 12'd64, 32'h1111_1111);
        for (int i = 0; i < 4; i++)
            drive(1, 0, 4'h0, 32'h0000_0010, '0, 1, 1, 4'hF, 32'h0000_0100, 32'h1111_1111,
                  0, 1, 1, 4'hF, 12'd64, 32'h1111_1111);
        lock_val = 1'b0;
        drive(1, 0, 4'h0, 32'h0000_0010, '0, 1, 1, 4'hF, 32'h0000_0100, 32'h2222_2222,
              0, 1, 1, 4'hF, 12'd64, 32'h2222_2222);
        drive(1, 0, 4'h0, 32'h0000_0010, '0, 1, 1, 4'hF, 32'h0000_0100, 32'h2222_2222,
              1, 0, 0, 4'h0, 12'd4, '0);
        exp0_q.push_back(32'hDEAD_BEEF);
        idle();
`endif

        repeat (3) idle();
        @(posedge clk);
        #1;
        check("drain_cycle_q", 64'(cyc_q.size()), 64'(0));
        check("drain_m0_q", 64'(exp0_q.size()), 64'(0));
        check("drain_m1_q", 64'(exp1_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
